// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU and its sequencing controller.
package alu_pkg;

   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_t;

   typedef enum logic [1:0] {
      CMD_LOAD  = 2'd0,
      CMD_EXEC  = 2'd1,
      CMD_READ  = 2'd2,
      CMD_CLEAR = 2'd3
   } cmd_kind_t;

   typedef enum logic [1:0] {
      SEQ_IDLE    = 2'd0,
      SEQ_ISSUE   = 2'd1,
      SEQ_CAPTURE = 2'd2,
      SEQ_RESP    = 2'd3
   } seq_state_t;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU: ADD/SUB report carry out on v, AND/OR report v=0.
module alu4
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        op,
   output logic [DATA_W-1:0] s,
   output logic              v
);

   logic [DATA_W:0] sum;

   always_comb begin
      sum = '0;
      s   = '0;
      v   = 1'b0;
      case (alu_op_t'(op))
         ALU_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            s   = sum[DATA_W-1:0];
            v   = sum[DATA_W];
         end
         // Subtract as A + ~B + 1 so v=1 means no borrow.
         ALU_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
            s   = sum[DATA_W-1:0];
            v   = sum[DATA_W];
         end
         ALU_AND: s = a & b;
         ALU_OR:  s = a | b;
         default: s = '0;
      endcase
   end

endmodule

// File: rtl/alu4_core.sv
// Thin top pairing the sequencing controller with one combinational alu4.
module alu4_core
   import alu_pkg::*;
#(
   parameter bit                STICKY_OVF = 1'b1,
   parameter logic [DATA_W-1:0] ACC_INIT   = 4'h0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_kind,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_ovf,
   output logic              ovf_flag
);

   logic [DATA_W-1:0] alu_a, alu_b, alu_s;
   logic [1:0]        alu_op;
   logic              alu_v;

   alu4_seq #(
      .STICKY_OVF (STICKY_OVF),
      .ACC_INIT   (ACC_INIT)
   ) u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_kind  (cmd_kind),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_ovf   (rsp_ovf),
      .ovf_flag  (ovf_flag),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_s     (alu_s),
      .alu_v     (alu_v)
   );

   alu4 u_alu (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .s  (alu_s),
      .v  (alu_v)
   );

endmodule

// File: rtl/alu4_seq.sv
// Sequencing initiator: accepts accumulator commands, drives a registered
// ALU operand set, and returns results over a valid/ready response stream.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | cmd_ready=1; LOAD/READ/CLEAR answered directly, EXEC latched
//   ISSUE   | ALU inputs stable, combinational result settling
//   CAPTURE | ALU S/V sampled into acc, response and overflow flag
//   RESP    | response held until rsp_ready
module alu4_seq
   import alu_pkg::*;
#(
   parameter bit                STICKY_OVF = 1'b1,
   parameter logic [DATA_W-1:0] ACC_INIT   = 4'h0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_kind,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_ovf,
   output logic              ovf_flag,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_s,
   input  logic              alu_v
);

   seq_state_t        state, state_nx;
   cmd_kind_t         kind;
   logic              accept;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_direct;

   assign kind      = cmd_kind_t'(cmd_kind);
   assign cmd_ready = (state == SEQ_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= SEQ_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SEQ_IDLE:    if (accept) state_nx = (kind == CMD_EXEC) ? SEQ_ISSUE : SEQ_RESP;
         SEQ_ISSUE:   state_nx = SEQ_CAPTURE;
         SEQ_CAPTURE: state_nx = SEQ_RESP;
         SEQ_RESP:    if (rsp_ready) state_nx = SEQ_IDLE;
         default:     state_nx = SEQ_IDLE;
      endcase
   end

   // Accumulator value for commands that bypass the ALU.
   always_comb begin
      acc_direct = acc;
      case (kind)
         CMD_LOAD:  acc_direct = cmd_data;
         CMD_CLEAR: acc_direct = ACC_INIT;
         default:   acc_direct = acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= ACC_INIT;
         alu_a     <= ACC_INIT;
         alu_b     <= '0;
         alu_op    <= ALU_ADD;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_ovf   <= 1'b0;
         ovf_flag  <= 1'b0;
      end else begin
         case (state)
            SEQ_IDLE: begin
               if (accept) begin
                  if (kind == CMD_EXEC) begin
                     alu_b  <= cmd_data;
                     alu_op <= cmd_op;
                  end else begin
                     acc       <= acc_direct;
                     alu_a     <= acc_direct;
                     rsp_data  <= acc_direct;
                     rsp_ovf   <= 1'b0;
                     rsp_valid <= 1'b1;
                     if (kind == CMD_CLEAR) ovf_flag <= 1'b0;
                  end
               end
            end
            SEQ_CAPTURE: begin
               acc       <= alu_s;
               alu_a     <= alu_s;
               rsp_data  <= alu_s;
               rsp_ovf   <= alu_v;
               rsp_valid <= 1'b1;
               ovf_flag  <= STICKY_OVF ? (ovf_flag | alu_v) : alu_v;
            end
            SEQ_RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu4_seq.sv
// Directed bench for alu4_seq (bench-side ALU) with a parallel alu4_core copy.
module tb_alu4_seq;

   localparam logic [1:0] K_LOAD = 2'd0, K_EXEC = 2'd1, K_READ = 2'd2, K_CLEAR = 2'd3;
   localparam logic [1:0] O_ADD = 2'd0, O_SUB = 2'd1, O_AND = 2'd2, O_OR = 2'd3;
   localparam logic [3:0] INIT = 4'h0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_kind = 2'd0;
   logic [1:0] cmd_op = 2'd0;
   logic [3:0] cmd_data = 4'd0;
   logic       rsp_ready = 1'b0;

   logic       cmd_ready, rsp_valid, rsp_ovf, ovf_flag, alu_v;
   logic [3:0] rsp_data, alu_a, alu_b, alu_s;
   logic [1:0] alu_op;

   logic       core_cmd_ready, core_rsp_valid, core_rsp_ovf, core_ovf_flag;
   logic [3:0] core_rsp_data;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [3:0] exp_acc = INIT;
   logic       exp_flag = 1'b0;
   logic [3:0] exp_data = 4'd0;
   logic       exp_ovf = 1'b0;
   bit         settled = 1'b0;

   always #5 clk = ~clk;

   // Spec-level ALU: plain integer arithmetic, wrap modulo 16.
   function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (op)
         O_ADD: begin r = ia + ib; return {(r > 15), 4'(r % 16)}; end
         O_SUB: begin r = ia - ib; return {(ia >= ib), 4'((r + 16) % 16)}; end
         O_AND: return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   assign {alu_v, alu_s} = alu_ref(alu_op, alu_a, alu_b);

   alu4_seq #(.STICKY_OVF(1'b1), .ACC_INIT(INIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
      .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf), .ovf_flag(ovf_flag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s), .alu_v(alu_v)
   );

   alu4_core #(.STICKY_OVF(1'b1), .ACC_INIT(INIT)) core (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(core_cmd_ready), .cmd_kind(cmd_kind),
      .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(core_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(core_rsp_data),
      .rsp_ovf(core_rsp_ovf), .ovf_flag(core_ovf_flag)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && settled) begin
            chk("acc_on_alu_a", {4'd0, alu_a}, {4'd0, exp_acc});
            chk("ovf_flag", {7'd0, ovf_flag}, {7'd0, exp_flag});
            chk("core_ovf_flag", {7'd0, core_ovf_flag}, {7'd0, exp_flag});
         end
         if (rsp_valid) begin
            chk("rsp_data", {4'd0, rsp_data}, {4'd0, exp_data});
            chk("rsp_ovf", {7'd0, rsp_ovf}, {7'd0, exp_ovf});
         end
         if (core_rsp_valid) begin
            chk("core_rsp_data", {4'd0, core_rsp_data}, {4'd0, exp_data});
            chk("core_rsp_ovf", {7'd0, core_rsp_ovf}, {7'd0, exp_ovf});
         end
      end
   end

   task automatic model_accept(input logic [1:0] kind, input logic [1:0] op, input logic [3:0] data);
      logic [4:0] r;
      case (kind)
         K_LOAD:  begin exp_acc = data; exp_ovf = 1'b0; end
         K_CLEAR: begin exp_acc = INIT; exp_flag = 1'b0; exp_ovf = 1'b0; end
         K_READ:  exp_ovf = 1'b0;
         default: begin
            r = alu_ref(op, exp_acc, data);
            exp_acc = r[3:0];
            exp_ovf = r[4];
            exp_flag = exp_flag | r[4];
         end
      endcase
      exp_data = exp_acc;
   endtask

   task automatic run_cmd(input string name, input logic [1:0] kind, input logic [1:0] op,
                          input logic [3:0] data, input int stall,
                          input logic [3:0] lit_data, input logic lit_ovf, input logic lit_flag);
      int k;
      @(negedge clk);
      chk({name, "_ready"}, {7'd0, cmd_ready}, 8'd1);
      cmd_valid = 1'b1;
      cmd_kind  = kind;
      cmd_op    = op;
      cmd_data  = data;
      rsp_ready = 1'b0;
      @(posedge clk);
      if (kind == K_EXEC) settled = 1'b0;
      model_accept(kind, op, data);
      @(negedge clk);
      // Junk command held on the bus while busy must be ignored.
      cmd_kind = K_LOAD;
      cmd_data = 4'hF;
      k = 1;
      while (!rsp_valid && k < 8) begin
         @(negedge clk);
         k++;
      end
      if (!rsp_valid) begin
         chk({name, "_rsp_timeout"}, 8'd0, 8'd1);
         cmd_valid = 1'b0;
         settled = 1'b1;
         return;
      end
      settled = 1'b1;
      chk({name, "_latency"}, 8'(k), (kind == K_EXEC) ? 8'd3 : 8'd1);
      chk({name, "_lit_data"}, {4'd0, rsp_data}, {4'd0, lit_data});
      chk({name, "_lit_ovf"}, {7'd0, rsp_ovf}, {7'd0, lit_ovf});
      chk({name, "_lit_flag"}, {7'd0, ovf_flag}, {7'd0, lit_flag});
      chk({name, "_core_valid"}, {7'd0, core_rsp_valid}, 8'd1);
      chk({name, "_core_data"}, {4'd0, core_rsp_data}, {4'd0, lit_data});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({name, "_hold_valid"}, {7'd0, rsp_valid}, 8'd1);
         chk({name, "_hold_data"}, {4'd0, rsp_data}, {4'd0, lit_data});
         chk({name, "_hold_ovf"}, {7'd0, rsp_ovf}, {7'd0, lit_ovf});
         chk({name, "_hold_busy"}, {7'd0, cmd_ready}, 8'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({name, "_done_valid"}, {7'd0, rsp_valid}, 8'd0);
      chk({name, "_done_ready"}, {7'd0, cmd_ready}, 8'd1);
      chk({name, "_core_ready"}, {7'd0, core_cmd_ready}, 8'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
      chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
      chk("rst_rsp_data", {4'd0, rsp_data}, 8'd0);
      chk("rst_rsp_ovf", {7'd0, rsp_ovf}, 8'd0);
      chk("rst_alu_a", {4'd0, alu_a}, {4'd0, INIT});
      chk("rst_alu_b", {4'd0, alu_b}, 8'd0);
      chk("rst_alu_op", {6'd0, alu_op}, {6'd0, O_ADD});
      chk("rst_flag", {7'd0, ovf_flag}, 8'd0);
      settled = 1'b1;

      //       name          kind     op     data  stall lit   ovf   flag
      run_cmd("load5",      K_LOAD,  O_ADD, 4'h5, 0, 4'h5, 1'b0, 1'b0);
      run_cmd("add3",       K_EXEC,  O_ADD, 4'h3, 0, 4'h8, 1'b0, 1'b0);
      run_cmd("add9",       K_EXEC,  O_ADD, 4'h9, 0, 4'h1, 1'b1, 1'b1);
      run_cmd("or0",        K_EXEC,  O_OR,  4'h0, 0, 4'h1, 1'b0, 1'b1);
      run_cmd("clear1",     K_CLEAR, O_ADD, 4'h7, 0, 4'h0, 1'b0, 1'b0);
      run_cmd("load3",      K_LOAD,  O_ADD, 4'h3, 0, 4'h3, 1'b0, 1'b0);
      run_cmd("sub1",       K_EXEC,  O_SUB, 4'h1, 0, 4'h2, 1'b1, 1'b1);
      run_cmd("sub5",       K_EXEC,  O_SUB, 4'h5, 0, 4'hD, 1'b0, 1'b1);
      run_cmd("loadC",      K_LOAD,  O_ADD, 4'hC, 0, 4'hC, 1'b0, 1'b1);
      run_cmd("andA",       K_EXEC,  O_AND, 4'hA, 0, 4'h8, 1'b0, 1'b1);
      run_cmd("or3",        K_EXEC,  O_OR,  4'h3, 0, 4'hB, 1'b0, 1'b1);
      run_cmd("read_bp",    K_READ,  O_ADD, 4'h2, 4, 4'hB, 1'b0, 1'b1);
      run_cmd("add1_bp",    K_EXEC,  O_ADD, 4'h1, 4, 4'hC, 1'b0, 1'b1);
      run_cmd("clear2",     K_CLEAR, O_ADD, 4'h0, 0, 4'h0, 1'b0, 1'b0);
      run_cmd("load6",      K_LOAD,  O_ADD, 4'h6, 0, 4'h6, 1'b0, 1'b0);

      // Reset during ISSUE of EXEC ADD 7.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_kind  = K_EXEC;
      cmd_op    = O_ADD;
      cmd_data  = 4'h7;
      @(posedge clk);
      settled = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("issue_alu_a", {4'd0, alu_a}, 8'h06);
      chk("issue_alu_b", {4'd0, alu_b}, 8'h07);
      chk("issue_alu_op", {6'd0, alu_op}, {6'd0, O_ADD});
      chk("issue_busy", {7'd0, cmd_ready}, 8'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_acc  = INIT;
      exp_flag = 1'b0;
      settled  = 1'b1;
      chk("mid_rst_ready", {7'd0, cmd_ready}, 8'd1);
      chk("mid_rst_valid", {7'd0, rsp_valid}, 8'd0);
      chk("mid_rst_alu_a", {4'd0, alu_a}, {4'd0, INIT});
      chk("mid_rst_alu_b", {4'd0, alu_b}, 8'd0);
      chk("mid_rst_data", {4'd0, rsp_data}, 8'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", {7'd0, rsp_valid}, 8'd0);
         chk("no_core_rsp_after_rst", {7'd0, core_rsp_valid}, 8'd0);
      end

      run_cmd("sub0_eq",    K_EXEC,  O_SUB, 4'h0, 0, 4'h0, 1'b1, 1'b1);
      run_cmd("clear3",     K_CLEAR, O_ADD, 4'h0, 0, 4'h0, 1'b0, 1'b0);
      run_cmd("addF",       K_EXEC,  O_ADD, 4'hF, 0, 4'hF, 1'b0, 1'b0);
      run_cmd("add1_wrap",  K_EXEC,  O_ADD, 4'h1, 1, 4'h0, 1'b1, 1'b1);
      run_cmd("read_end",   K_READ,  O_ADD, 4'h9, 0, 4'h0, 1'b0, 1'b1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
